sram_mem_stage: RTL and testbench
=================================

Name: sram_mem_stage

Overview:
- Memory stage between the EXE-stage register and the MEM/WB register.
- Turns 32-bit loads and stores into two 16-bit accesses on an external SRAM (low half first, then high half).
- Holds `ready` low while an access is in progress; the hazard/freeze logic uses `~ready` to stall every upstream pipeline register.
- Returns the assembled 32-bit load word to the WB path.

Parameters:
- DATA_BASE, 1024: byte address that maps to SRAM word 0.
- ACCESS_CYC, 2: clock cycles each 16-bit SRAM access is held (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- MEM_R_EN  input  1  load request from the EXE-stage register
- MEM_W_EN  input  1  store request from the EXE-stage register
- ALU_result  input  32  byte address
- ST_val  input  32  store data
- ready  output  1  1 = no access pending or access complete this cycle
- MEM_result  output  32  last completed load word (registered)
- sram_addr  output  18  SRAM half-word address
- sram_we_n  output  1  SRAM write strobe, active-low
- sram_dq_out  output  16  write data to the SRAM
- sram_dq_oe  output  1  1 = drive `sram_dq_out` onto the SRAM bus
- sram_dq_in  input  16  read data from the SRAM

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE, counter = 0.
  - MEM_result = 0, latched address and data = 0.
  - Outputs: sram_addr = 0, sram_we_n = 1, sram_dq_oe = 0, sram_dq_out = 0.
  - Reset in the middle of an access aborts it immediately: no further write strobe and MEM_result is not updated.
- Address map:
  - off = ALU_result − DATA_BASE, computed as a 32-bit subtraction.
  - idx = off[18:2], 17 bits. Addresses out of range wrap modulo 2^17 words with no error.
  - off[1:0] is ignored.
  - Low half-word is at {idx,0}; high half-word is at {idx,1}.
- Request: req = MEM_R_EN | MEM_W_EN. If both are high, treat it as a write.
- FSM states are IDLE, LOW, HIGH and DONE, with a counter cnt.
  - IDLE:
    - ready = ~req.
    - If req: latch idx, ST_val and is_wr; set cnt = 0; go to LOW.
  - LOW:
    - sram_addr = {idx,0}.
    - If write: sram_dq_out = data[15:0], sram_dq_oe = 1, sram_we_n = 0.
    - cnt increments each cycle.
    - On the last cycle (cnt = ACCESS_CYC−1): if read, capture sram_dq_in into lo; go to HIGH with cnt = 0.
  - HIGH:
    - Same as LOW, but uses {idx,1} and data[31:16].
    - On the last cycle: if read, MEM_result ← {sram_dq_in, lo}; go to DONE.
  - DONE:
    - ready = 1, sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0.
    - Unconditionally go to IDLE next cycle.
- Output values outside LOW/HIGH: sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0.
- Ready timing:
  - ready = 0 in LOW and HIGH.
  - Occupancy: request cycle + 2·ACCESS_CYC + 1. This is 6 cycles at the default, and ready is 0 for the first 5.
- Input stability:
  - The pipeline is frozen, so inputs stay stable until DONE.
  - Address and data are latched at IDLE→LOW regardless, so input changes during LOW or HIGH have no effect.
  - A request still asserted in DONE does not restart an access.
  - A new request is recognised only in IDLE.
- Back-to-back: the next request is seen in the IDLE cycle right after DONE, so there is no dead cycle beyond DONE→IDLE.
- A store never modifies MEM_result.
- Combinational outputs (ready, SRAM signals) depend only on state, cnt, latched values and req. There is no combinational path from sram_dq_in to any output.

Test Plan:
- Reset: hold rst=0 with random inputs → MEM_result = 0, sram_we_n = 1, sram_dq_oe = 0, ready = 1 when MEM_R_EN = MEM_W_EN = 0.
- Store: ALU_result = 1032, ST_val = 0xDEADBEEF, MEM_W_EN held → check each of the following:
  - sram_addr = 4 with dq_out = 0xBEEF and we_n = 0 for 2 cycles.
  - then sram_addr = 5 with dq_out = 0xDEAD for 2 cycles.
  - ready = 0 for 5 cycles, then 1 for 1 cycle.
- Load: SRAM model holds 4 → 0xBEEF and 5 → 0xDEAD; MEM_R_EN with address 1032 → MEM_result = 0xDEADBEEF in the DONE cycle, we_n stays 1, dq_oe stays 0.
- Back-to-back: store to 1024, then load from 1024 with the request held across DONE → exactly two accesses occur, the load returns the stored value, and there is no spurious third access.
- Reset mid-op: rst=0 during HIGH of a load → sram_we_n = 1 immediately, MEM_result = 0, state IDLE after release.
- Edge cases:
  - MEM_R_EN = MEM_W_EN = 1 → performed as a write.
  - ALU_result = 1024 + 4·131071 → sram_addr 262142 then 262143.
  - ALU_result = 1020 → wraps to idx 131071.
  - ACCESS_CYC = 1 → ready = 0 for 3 cycles.

Source files
------------

// File: rtl/sram_mem_stage_if.sv
// External SRAM bus seen by the memory stage: 18-bit half-word address,
// active-low write strobe and a split 16-bit data bus with output enable.
interface sram_mem_stage_if;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    modport master (
        output sram_addr,
        output sram_we_n,
        output sram_dq_out,
        output sram_dq_oe,
        input  sram_dq_in
    );

    modport slave (
        input  sram_addr,
        input  sram_we_n,
        input  sram_dq_out,
        input  sram_dq_oe,
        output sram_dq_in
    );
endinterface

// File: rtl/sram_mem_stage.sv
// Memory stage: splits each 32-bit load/store into two 16-bit SRAM accesses
// (low half first) and stalls the pipeline through `ready` until both finish.
module sram_mem_stage #(
    parameter int DATA_BASE  = 1024,
    parameter int ACCESS_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic [31:0]      ALU_result,
    input  logic [31:0]      ST_val,
    output logic             ready,
    output logic [31:0]      MEM_result,
    sram_mem_stage_if.master sram
);

    localparam int               CNT_W    = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYC - 1);
    localparam logic [31:0]      BASE     = 32'(DATA_BASE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [16:0]      r_idx;
    logic [31:0]      r_data;
    logic             r_is_wr;
    logic [15:0]      r_lo;
    logic [31:0]      r_mem_result;

    logic             w_req;
    logic             w_last;
    logic [31:0]      w_off;
    logic [16:0]      w_idx;
    logic             w_unused_off;
    logic             w_ready;
    logic [17:0]      w_addr;
    logic             w_we_n;
    logic             w_oe;
    logic [15:0]      w_dq_out;

    assign w_req        = MEM_R_EN | MEM_W_EN;
    assign w_off        = ALU_result - BASE;
    // Byte offset bits and anything above the 2^17-word window are dropped: wrap, no fault.
    assign w_idx        = w_off[18:2];
    assign w_unused_off = ^{w_off[31:19], w_off[1:0]};
    assign w_last       = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_addr      = '0;
        w_we_n      = 1'b1;
        w_oe        = 1'b0;
        w_dq_out    = '0;
        case (r_state)
            ST_IDLE: begin
                w_ready = ~w_req;
                if (w_req) begin
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                w_addr = {r_idx, 1'b0};
                w_we_n = ~r_is_wr;
                w_oe   = r_is_wr;
                if (r_is_wr) begin
                    w_dq_out = r_data[15:0];
                end
                if (w_last) begin
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                w_addr = {r_idx, 1'b1};
                w_we_n = ~r_is_wr;
                w_oe   = r_is_wr;
                if (r_is_wr) begin
                    w_dq_out = r_data[31:16];
                end
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            // DONE never looks at the request, so a request held by the frozen pipeline cannot restart.
            ST_DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_data       <= '0;
            r_is_wr      <= 1'b0;
            r_lo         <= '0;
            r_mem_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_idx   <= w_idx;
                        r_data  <= ST_val;
                        r_is_wr <= MEM_W_EN;
                        r_cnt   <= '0;
                    end
                end
                ST_LOW: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!r_is_wr) begin
                            r_lo <= sram.sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!r_is_wr) begin
                            r_mem_result <= {sram.sram_dq_in, r_lo};
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready            = w_ready;
    assign MEM_result       = r_mem_result;
    assign sram.sram_addr   = w_addr;
    assign sram.sram_we_n   = w_we_n;
    assign sram.sram_dq_oe  = w_oe;
    assign sram.sram_dq_out = w_dq_out;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench for sram_mem_stage: two instances (ACCESS_CYC 2 and 1) against a
// word-level reference memory and per-cycle expectations derived from the access timing.
module tb_sram_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] alu0, st0, alu1, st1;
    logic [31:0] res0, res1;
    logic        rdy0, rdy1;

    sram_mem_stage_if bus0 ();
    sram_mem_stage_if bus1 ();

    sram_mem_stage #(.DATA_BASE(1024), .ACCESS_CYC(2)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(rd0), .MEM_W_EN(wr0),
        .ALU_result(alu0), .ST_val(st0), .ready(rdy0), .MEM_result(res0),
        .sram(bus0)
    );

    sram_mem_stage #(.DATA_BASE(1024), .ACCESS_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(rd1), .MEM_W_EN(wr1),
        .ALU_result(alu1), .ST_val(st1), .ready(rdy1), .MEM_result(res1),
        .sram(bus1)
    );

    // Half-word SRAM devices: combinational read, write on the clock while strobe is low.
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    assign bus0.sram_dq_in = mem0[bus0.sram_addr];
    assign bus1.sram_dq_in = mem1[bus1.sram_addr];
    always @(posedge clk) begin
        if (!bus0.sram_we_n) mem0[bus0.sram_addr] <= bus0.sram_dq_out;
        if (!bus1.sram_we_n) mem1[bus1.sram_addr] <= bus1.sram_dq_out;
    end

    bit          sel;
    logic        o_rdy, o_we_n, o_oe;
    logic [17:0] o_addr;
    logic [15:0] o_dq;
    logic [31:0] o_res;
    always_comb begin
        o_rdy  = sel ? rdy1 : rdy0;
        o_we_n = sel ? bus1.sram_we_n : bus0.sram_we_n;
        o_oe   = sel ? bus1.sram_dq_oe : bus0.sram_dq_oe;
        o_addr = sel ? bus1.sram_addr : bus0.sram_addr;
        o_dq   = sel ? bus1.sram_dq_out : bus0.sram_dq_out;
        o_res  = sel ? res1 : res0;
    end

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_res [2];
    logic [31:0] stored [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off / 32'd4) % 32'd131072);
    endfunction

    task automatic drive(input bit s, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        if (s) begin
            rd1 = rd; wr1 = wr; alu1 = a; st1 = d;
        end else begin
            rd0 = rd; wr0 = wr; alu0 = a; st0 = d;
        end
    endtask

    // One full access, request held from the IDLE cycle through DONE.
    task automatic txn(input bit s, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d, input string tag);
        int ac, ix, key;
        bit in_lo, in_hi, done;
        logic [31:0] old_v, new_v;
        ac = s ? 1 : 2;
        ix = idx_of(a);
        key = (s ? 262144 : 0) + ix;
        old_v = exp_res[s];
        new_v = old_v;
        if (wr) ref_mem[key] = d;
        else new_v = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        @(negedge clk);
        sel = s;
        drive(s, rd, wr, a, d);
        for (int c = 0; c <= 2 * ac + 1; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            in_lo = (c >= 1) && (c <= ac);
            in_hi = (c > ac) && (c <= 2 * ac);
            done  = (c == 2 * ac + 1);
            chk({tag, ".ready"}, 32'(o_rdy), 32'(done));
            chk({tag, ".we_n"}, 32'(o_we_n), 32'((in_lo || in_hi) ? !wr : 1'b1));
            chk({tag, ".oe"}, 32'(o_oe), 32'((in_lo || in_hi) && wr));
            chk({tag, ".addr"}, 32'(o_addr), in_lo ? 32'(ix * 2) : in_hi ? 32'(ix * 2 + 1) : 32'd0);
            if ((in_lo || in_hi) && wr)
                chk({tag, ".dq"}, 32'(o_dq), in_lo ? 32'(d[15:0]) : 32'(d[31:16]));
            chk({tag, ".result"}, o_res, done ? new_v : old_v);
        end
        exp_res[s] = new_v;
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
            alu0 = $urandom; st0 = $urandom;
            #1;
            chk({tag, ".ready"}, 32'(o_rdy), 32'd1);
            chk({tag, ".we_n"}, 32'(o_we_n), 32'd1);
            chk({tag, ".oe"}, 32'(o_oe), 32'd0);
            chk({tag, ".addr"}, 32'(o_addr), 32'd0);
            chk({tag, ".result"}, o_res, exp_res[sel]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r_wr, r_rd;
        logic [31:0] a, d;
        sel = 1'b0;
        rst = 1'b0;
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        alu0 = '0; st0 = '0; alu1 = '0; st1 = '0;
        exp_res[0] = '0;
        exp_res[1] = '0;

        repeat (4) begin
            @(negedge clk);
            rd0 = 1'($urandom); wr0 = 1'($urandom);
            alu0 = $urandom; st0 = $urandom;
            #1;
            chk("rst.result", o_res, 32'd0);
            chk("rst.we_n", 32'(o_we_n), 32'd1);
            chk("rst.oe", 32'(o_oe), 32'd0);
            chk("rst.addr", 32'(o_addr), 32'd0);
            chk("rst.ready", 32'(o_rdy), 32'(!(rd0 | wr0)));
        end
        @(negedge clk);
        rd0 = 1'b0; wr0 = 1'b0;
        #1;
        chk("rst.ready_idle", 32'(o_rdy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        idle(2, "idle");

        txn(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, "store");
        txn(0, 1'b1, 1'b0, 32'd1032, 32'h0, "load");
        txn(0, 1'b1, 1'b1, 32'd1040, 32'h12345678, "both");
        txn(0, 1'b1, 1'b0, 32'd1040, 32'h0, "both_rd");

        txn(0, 1'b0, 1'b1, 32'd1024, 32'hA5A55A5A, "b2b_st");
        txn(0, 1'b1, 1'b0, 32'd1024, 32'h0, "b2b_ld");
        idle(2, "b2b_after");

        txn(0, 1'b0, 1'b1, 32'd1024 + 32'd4 * 32'd131071, 32'hCAFE0001, "top_st");
        txn(0, 1'b1, 1'b0, 32'd1024 + 32'd4 * 32'd131071, 32'h0, "top_ld");
        txn(0, 1'b0, 1'b1, 32'd1020, 32'h0BAD0F00, "wrap_st");
        txn(0, 1'b1, 1'b0, 32'd1020, 32'h0, "wrap_ld");
        txn(0, 1'b1, 1'b0, 32'd1032, 32'h0, "reload");

        // Abort a load in its high half with reset.
        @(negedge clk);
        sel = 1'b0;
        drive(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("mid.high_addr", 32'(o_addr), 32'd5);
        rst = 1'b0;
        #1;
        chk("mid.we_n", 32'(o_we_n), 32'd1);
        chk("mid.addr", 32'(o_addr), 32'd0);
        chk("mid.result", o_res, 32'd0);
        chk("mid.ready", 32'(o_rdy), 32'd0);
        exp_res[0] = '0;
        exp_res[1] = '0;
        @(negedge clk);
        rd0 = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid.ready_after", 32'(o_rdy), 32'd1);
        txn(0, 1'b1, 1'b0, 32'd1032, 32'h0, "mid_reload");

        txn(1, 1'b0, 1'b1, 32'd1100, 32'h89ABCDEF, "ac1_st");
        txn(1, 1'b1, 1'b0, 32'd1100, 32'h0, "ac1_ld");
        txn(1, 1'b1, 1'b1, 32'd1020, 32'h00C0FFEE, "ac1_both");
        txn(1, 1'b1, 1'b0, 32'd1020, 32'h0, "ac1_both_rd");
        idle(1, "ac1_idle");

        for (int i = 0; i < 40; i++) begin
            r_wr = 1'($urandom) || (stored.size() == 0);
            if (r_wr) begin
                if ($urandom_range(0, 1) == 1)
                    a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 3));
                else
                    a = $urandom;
                d = $urandom;
                r_rd = 1'($urandom);
                stored.push_back(a);
            end else begin
                a = stored[$urandom_range(0, stored.size() - 1)];
                d = $urandom;
                r_rd = 1'b1;
            end
            txn(0, r_rd, r_wr, a, d, r_wr ? "rnd_st" : "rnd_ld");
            idle(int'($urandom_range(0, 2)), "rnd_idle");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
